// File: rtl/des_pkg.sv
// Shared DES key-schedule types and constants: PC-1, PC-2, the per-round shift schedule
// and a 28-bit rotate used on the C and D halves.
package des_pkg;

   typedef logic [0:47]       subkey_t;
   typedef logic [0:27]       half_t;
   typedef logic [0:15][0:47] round_keys_t;

   typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

   // Table entries are 1-based DES bit positions.
   localparam int unsigned PC1_TABLE [0:55] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int unsigned PC2_TABLE [0:47] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   localparam int unsigned SHIFT_SCHED [0:15] = '{
      1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
   };

   // Rotate left toward bit 0 within a 28-bit half.
   function automatic half_t rotl28(input half_t h, input int unsigned s);
      half_t r;
      r = '0;
      for (int unsigned i = 0; i < 28; i++) begin
         r[i] = h[5'((i + s) % 28)];
      end
      return r;
   endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression permutation: 56-bit {C,D} to one 48-bit round subkey.
module des_pc2
   import des_pkg::*;
(
   input  logic [0:55] cd,
   output subkey_t     subkey
);

   // Eight bit positions of {C,D} are dropped by PC-2.
   logic unused_cd;
   assign unused_cd = ^{cd[8], cd[17], cd[21], cd[24], cd[34], cd[37], cd[42], cd[53]};

   always_comb begin
      subkey = '0;
      for (int unsigned i = 0; i < 48; i++) begin
         subkey[i] = cd[6'(PC2_TABLE[i] - 1)];
      end
   end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: one subkey per cycle into a 16-slot array held stable
// for the cipher core; decrypt reverses slot order.
module des_key_schedule
   import des_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [0:63] key_in,
   input  logic        decrypt,
   input  logic        key_valid_in,
   output logic        key_ready,
   output round_keys_t round_keys,
   output logic        keys_valid
);

   state_t      state_q, state_d;
   half_t       c_q, d_q, c_nxt, d_nxt;
   logic [0:55] pc1_cd;
   logic [3:0]  cnt_q;
   logic [3:0]  slot_idx;
   logic        dir_q;
   logic        accept;
   round_keys_t slots_q;
   subkey_t     subkey;

   logic unused_parity;
   assign unused_parity = ^{key_in[7], key_in[15], key_in[23], key_in[31],
                            key_in[39], key_in[47], key_in[55], key_in[63]};

   always_comb begin
      pc1_cd = '0;
      for (int unsigned i = 0; i < 56; i++) begin
         pc1_cd[i] = key_in[6'(PC1_TABLE[i] - 1)];
      end
   end

   assign accept   = key_valid_in && (state_q != GEN);
   assign c_nxt    = rotl28(c_q, SHIFT_SCHED[cnt_q]);
   assign d_nxt    = rotl28(d_q, SHIFT_SCHED[cnt_q]);
   assign slot_idx = dir_q ? (4'd15 - cnt_q) : cnt_q;

   des_pc2 u_pc2 (
      .cd     ({c_nxt, d_nxt}),
      .subkey (subkey)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: if (key_valid_in)  state_d = GEN;
         GEN:        if (cnt_q == 4'd15) state_d = DONE;
         default:    state_d = IDLE;
      endcase
   end

   always_comb begin
      key_ready  = (state_q != GEN);
      keys_valid = (state_q == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         c_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         slots_q <= '0;
      end else if (accept) begin
         c_q   <= pc1_cd[0:27];
         d_q   <= pc1_cd[28:55];
         dir_q <= decrypt;
         cnt_q <= '0;
      end else if (state_q == GEN) begin
         c_q               <= c_nxt;
         d_q               <= d_nxt;
         slots_q[slot_idx] <= subkey;
         cnt_q             <= cnt_q + 4'd1;
      end
   end

   assign round_keys = slots_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule against a cumulative-shift integer model.
module tb_des_key_schedule;

   logic              clk = 1'b0;
   logic              rst;
   logic [0:63]       key_in;
   logic              decrypt;
   logic              key_valid_in;
   logic              key_ready;
   logic [0:15][0:47] round_keys;
   logic              keys_valid;

   int n_cmp = 0;
   int n_bad = 0;

   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };
   localparam int PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };
   localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   des_key_schedule dut (
      .clk          (clk),
      .rst          (rst),
      .key_in       (key_in),
      .decrypt      (decrypt),
      .key_valid_in (key_valid_in),
      .key_ready    (key_ready),
      .round_keys   (round_keys),
      .keys_valid   (keys_valid)
   );

   always #5 clk = ~clk;

   // Round r subkey: halves rotated by the cumulative shift count, values MSB = DES bit 1.
   function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int r);
      logic [27:0] c, d;
      logic [55:0] cd;
      logic [47:0] o;
      int          t;
      c = '0;
      d = '0;
      for (int j = 0; j < 28; j++) begin
         c = {c[26:0], key[6'(64 - PC1_T[j])]};
         d = {d[26:0], key[6'(64 - PC1_T[28 + j])]};
      end
      t = 0;
      for (int j = 0; j <= r; j++) t += SHIFTS[j];
      t = t % 28;
      c = (c << t) | (c >> (28 - t));
      d = (d << t) | (d >> (28 - t));
      cd = {c, d};
      o = '0;
      for (int j = 0; j < 48; j++) o = {o[46:0], cd[6'(56 - PC2_T[j])]};
      return o;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_slots(input string tag, input logic [63:0] k, input logic dec);
      for (int s = 0; s < 16; s++) begin
         check($sformatf("%s_slot%0d", tag, s), 64'(round_keys[s]),
               64'(ref_subkey(k, dec ? 15 - s : s)));
      end
   endtask

   task automatic start_key(input string tag, input logic [63:0] k, input logic dec, input bit hold);
      int w = 0;
      while (!key_ready && w < 40) begin
         @(posedge clk); #1;
         w++;
      end
      check({tag, "_ready_before"}, 64'(key_ready), 64'd1);
      @(negedge clk);
      key_in       = k;
      decrypt      = dec;
      key_valid_in = 1'b1;
      @(posedge clk); #1;
      if (!hold) key_valid_in = 1'b0;
      check({tag, "_ready_after_accept"}, 64'(key_ready), 64'd0);
      check({tag, "_valid_after_accept"}, 64'(keys_valid), 64'd0);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      bit ready_seen = 1'b0;
      while (!keys_valid && n < 40) begin
         if (key_ready) ready_seen = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_latency"}, 64'(n), 64'd16);
      check({tag, "_ready_during_gen"}, 64'(ready_seen), 64'd0);
      check({tag, "_ready_done"}, 64'(key_ready), 64'd1);
   endtask

   initial begin
      logic [63:0] k;
      logic        d;

      rst = 1'b1; key_in = '0; decrypt = 1'b0; key_valid_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", 64'(key_ready), 64'd1);
      check("reset_valid", 64'(keys_valid), 64'd0);
      check("reset_slot0", 64'(round_keys[0]), 64'd0);
      check("reset_slot15", 64'(round_keys[15]), 64'd0);
      @(negedge clk); rst = 1'b0;

      // Known-answer key, encrypt then decrypt order
      start_key("kat_enc", 64'h133457799BBCDFF1, 1'b0, 1'b0);
      wait_done("kat_enc");
      check("kat_enc_k0", 64'(round_keys[0]), 64'h1B02EFFC7072);
      check("kat_enc_k15", 64'(round_keys[15]), 64'hCB3D8B0E17F5);
      check_slots("kat_enc", 64'h133457799BBCDFF1, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      check("hold_valid", 64'(keys_valid), 64'd1);
      check_slots("hold", 64'h133457799BBCDFF1, 1'b0);

      start_key("kat_dec", 64'h133457799BBCDFF1, 1'b1, 1'b0);
      wait_done("kat_dec");
      check("kat_dec_k0", 64'(round_keys[0]), 64'hCB3D8B0E17F5);
      check("kat_dec_k15", 64'(round_keys[15]), 64'h1B02EFFC7072);
      check_slots("kat_dec", 64'h133457799BBCDFF1, 1'b1);

      // Weak keys and parity insensitivity
      start_key("weak0", 64'h0101010101010101, 1'b0, 1'b0);
      wait_done("weak0");
      for (int s = 0; s < 16; s++) check($sformatf("weak0_slot%0d", s), 64'(round_keys[s]), 64'h0);
      start_key("weakF", 64'hFEFEFEFEFEFEFEFE, 1'b0, 1'b0);
      wait_done("weakF");
      for (int s = 0; s < 16; s++) check($sformatf("weakF_slot%0d", s), 64'(round_keys[s]), 64'hFFFFFFFFFFFF);
      start_key("parity", 64'h0000000000000000, 1'b1, 1'b0);
      wait_done("parity");
      for (int s = 0; s < 16; s++) check($sformatf("parity_slot%0d", s), 64'(round_keys[s]), 64'h0);

      // Second request held high through GEN is ignored, then accepted in DONE
      start_key("held_a", 64'h0E329232EA6D0D73, 1'b0, 1'b1);
      @(negedge clk); key_in = 64'hAABB09182736CCDD;
      wait_done("held_a");
      check_slots("held_a", 64'h0E329232EA6D0D73, 1'b0);
      @(posedge clk); #1;
      key_valid_in = 1'b0;
      check("held_b_valid_drop", 64'(keys_valid), 64'd0);
      check("held_b_ready_drop", 64'(key_ready), 64'd0);
      wait_done("held_b");
      check_slots("held_b", 64'hAABB09182736CCDD, 1'b0);

      // Reset in the middle of generation
      start_key("abort", 64'h3B3898371520F75E, 1'b0, 1'b0);
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_ready", 64'(key_ready), 64'd1);
      check("abort_valid", 64'(keys_valid), 64'd0);
      for (int s = 0; s < 16; s++) check($sformatf("abort_slot%0d", s), 64'(round_keys[s]), 64'h0);
      start_key("after_abort", 64'h3B3898371520F75E, 1'b1, 1'b0);
      wait_done("after_abort");
      check_slots("after_abort", 64'h3B3898371520F75E, 1'b1);

      // Random keys and directions
      for (int i = 0; i < 8; i++) begin
         k = {$urandom, $urandom};
         d = 1'($urandom_range(0, 1));
         start_key($sformatf("rnd%0d", i), k, d, 1'b0);
         wait_done($sformatf("rnd%0d", i));
         check_slots($sformatf("rnd%0d", i), k, d);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
